i2c_target_pot: RTL and testbench

- I2C target (responder) emulating the single-register digital potentiometer that our i2c_controller writes to at address 0x2F.
- Decodes START/STOP, matches the 7-bit address, ACKs, and latches write data into a wiper register. Returns the wiper value on reads.
- Used as a loopback model in the bench and as a drop-in FPGA-side wiper target driving downstream PWM/DAC logic.
- Open-drain SDA is exposed as an enable. The top level wires it through a tristated pull-up SB_IO.

---
 rtl/i2c_target_pot.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target_pot.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_pot.sv
// rtl/i2c_target_pot.sv - I2C target emulating a single-register digital potentiometer
module i2c_target_pot #(
    parameter logic [6:0] TARGET_ADDR = 7'h2F,
    parameter int         MAX_VALUE   = 127,
    parameter int         RESET_VALUE = 0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] wiper,
    output logic       wiper_wr,
    output logic       busy
);

    localparam logic [7:0] MAX_V = 8'(MAX_VALUE);
    localparam logic [7:0] RST_V = 8'(RESET_VALUE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t     r_state,    w_state_nxt;
    logic [3:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic [7:0] r_shift,    w_shift_nxt;
    logic       r_rw,       w_rw_nxt;
    logic       r_sda_oe,   w_sda_oe_nxt;
    logic [7:0] r_wiper,    w_wiper_nxt;
    logic       r_wiper_wr, w_wiper_wr_nxt;
    logic       r_busy,     w_busy_nxt;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_in_byte;

    // Sync chains idle high so a reset never fabricates a bus edge from a released bus
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be stable high across both samples; a coincident SCL edge makes it a data bit
    assign w_start    = ~w_sda & r_sda_d & w_scl & r_scl_d;
    assign w_stop     = w_sda & ~r_sda_d & w_scl & r_scl_d;
    assign w_in_byte  = {r_shift[6:0], w_sda};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wiper    <= RST_V;
            r_wiper_wr <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_wiper    <= w_wiper_nxt;
            r_wiper_wr <= w_wiper_wr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rw_nxt       = r_rw;
        w_sda_oe_nxt   = r_sda_oe;
        w_wiper_nxt    = r_wiper;
        w_wiper_wr_nxt = 1'b0;
        w_busy_nxt     = r_busy;

        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_in_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            if (w_in_byte[7:1] == TARGET_ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_sda;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                // bit_cnt 0: waiting for the fall that starts ACK; 1: ninth clock seen
                S_ADDR_ACK, S_WRITE_ACK: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = 4'd0;
                            if (r_state == S_WRITE_ACK || !r_rw) begin
                                w_state_nxt  = S_WRITE;
                                w_sda_oe_nxt = 1'b0;
                            end else begin
                                w_state_nxt  = S_READ;
                                w_shift_nxt  = {r_wiper[6:0], 1'b0};
                                w_sda_oe_nxt = ~r_wiper[7];
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_in_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt  = 4'd0;
                            w_wiper_nxt    = (w_in_byte > MAX_V) ? MAX_V : w_in_byte;
                            w_wiper_wr_nxt = 1'b1;
                            w_state_nxt    = S_WRITE_ACK;
                        end
                    end
                end
                // r_shift[7] always holds the bit to present on the next falling edge
                S_READ: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_READ_ACK;
                        end else if (r_bit_cnt != 4'd0) begin
                            w_sda_oe_nxt = ~r_shift[7];
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                S_READ_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nxt = S_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_bit_cnt_nxt = 4'd1;
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_READ;
                        w_shift_nxt   = {r_wiper[6:0], 1'b0};
                        w_sda_oe_nxt  = ~r_wiper[7];
                    end
                end
                S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign wiper    = r_wiper;
    assign wiper_wr = r_wiper_wr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_pot.sv
// tb/tb_i2c_target_pot.sv - scoreboard bench for i2c_target_pot
`timescale 1ns/1ps
module tb_i2c_target_pot;

    localparam int T = 80;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] wiper;
    logic       wiper_wr;
    logic       busy;

    logic [15:0] q_bus_exp[$];
    logic [15:0] q_bus_obs[$];
    string       q_bus_name[$];
    logic [7:0]  q_wr_exp[$];

    int   errors = 0;
    int   checks = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_pot dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .wiper    (wiper),
        .wiper_wr (wiper_wr),
        .busy     (busy)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (wiper_wr !== 1'b0) begin
                if (q_wr_exp.size() == 0) check("wr_unexpected", 16'(wiper_wr), 16'd0);
                else check("wr_wiper", 16'(wiper), 16'(q_wr_exp.pop_front()));
            end
            while (q_bus_obs.size() > 0 && q_bus_exp.size() > 0)
                check(q_bus_name.pop_front(), q_bus_obs.pop_front(), q_bus_exp.pop_front());
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #T;
        m_scl = 1'b1; #T;
        m_sda = 1'b0; #T;
        m_scl = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #T;
        m_scl = 1'b1; #T;
        m_sda = 1'b1; #T;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #T;
        m_scl = 1'b1; #T;
        m_scl = 1'b0; #T;
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; #T;
        m_scl = 1'b1; #(T/2);
        b = sda_bus; #(T/2);
        m_scl = 1'b0; #T;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string nm);
        logic b;
        q_bus_exp.push_back(16'(exp_ack));
        q_bus_name.push_back(nm);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(b);
        q_bus_obs.push_back(16'(b));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic last, input string nm);
        logic [7:0] v;
        logic       b;
        q_bus_exp.push_back(16'(exp));
        q_bus_name.push_back(nm);
        if (last) begin
            q_bus_exp.push_back(16'd1);
            q_bus_name.push_back({nm, "_release"});
        end
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        q_bus_obs.push_back(16'(v));
        if (last) begin
            read_bit(b);
            q_bus_obs.push_back(16'(b));
        end else begin
            send_bit(1'b0);
        end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", 16'(sda_oe), 16'd0);
        check("rst_wiper", 16'(wiper), 16'd0);
        check("rst_wiper_wr", 16'(wiper_wr), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        reset_n = 1'b1;
        #(4*T);

        // write 0x4B
        i2c_start();
        write_byte(8'h5E, 1'b0, "t1_addr_ack");
        check("t1_busy_hi", 16'(busy), 16'd1);
        q_wr_exp.push_back(8'd75);
        write_byte(8'h4B, 1'b0, "t1_data_ack");
        i2c_stop();
        check("t1_busy_lo", 16'(busy), 16'd0);
        check("t1_wiper", 16'(wiper), 16'd75);

        // clamp
        i2c_start();
        write_byte(8'h5E, 1'b0, "t2_addr_ack");
        q_wr_exp.push_back(8'd127);
        write_byte(8'hC8, 1'b0, "t2_data_ack");
        i2c_stop();
        check("t2_wiper", 16'(wiper), 16'd127);

        // wrong address
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        write_byte(8'h5C, 1'b1, "t3_addr_nack");
        write_byte(8'h10, 1'b1, "t3_data_nack");
        i2c_stop();
        check("t3_oe_seen", 16'(oe_seen), 16'd0);
        check("t3_busy_seen", 16'(busy_seen), 16'd0);
        check("t3_wiper", 16'(wiper), 16'd127);

        // preload 0x5A then read with NACK
        i2c_start();
        write_byte(8'h5E, 1'b0, "t4_wr_addr_ack");
        q_wr_exp.push_back(8'h5A);
        write_byte(8'h5A, 1'b0, "t4_wr_data_ack");
        i2c_stop();
        i2c_start();
        write_byte(8'h5F, 1'b0, "t4_rd_addr_ack");
        read_byte(8'h5A, 1'b1, "t4_rd_byte");
        check("t4_busy_after_nack", 16'(busy), 16'd0);
        check("t4_oe_after_nack", 16'(sda_oe), 16'd0);
        i2c_stop();

        // write 0x20, repeated START, read twice
        i2c_start();
        write_byte(8'h5E, 1'b0, "t5_wr_addr_ack");
        q_wr_exp.push_back(8'h20);
        write_byte(8'h20, 1'b0, "t5_wr_data_ack");
        i2c_start();
        write_byte(8'h5F, 1'b0, "t5_rd_addr_ack");
        read_byte(8'h20, 1'b0, "t5_rd_byte0");
        read_byte(8'h20, 1'b1, "t5_rd_byte1");
        i2c_stop();
        check("t5_wiper", 16'(wiper), 16'h20);

        // reset during bit 4 of a data byte
        i2c_start();
        write_byte(8'h5E, 1'b0, "t6_addr_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        m_sda = 1'b1; #T;
        m_scl = 1'b1; #(T/2);
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_oe", 16'(sda_oe), 16'd0);
        check("t6_rst_wiper", 16'(wiper), 16'd0);
        check("t6_rst_busy", 16'(busy), 16'd0);
        reset_n = 1'b1;
        #(T/2);
        m_scl = 1'b0; #T;
        i2c_stop();
        i2c_start();
        write_byte(8'h5E, 1'b0, "t6_post_addr_ack");
        q_wr_exp.push_back(8'h11);
        write_byte(8'h11, 1'b0, "t6_post_data_ack");
        i2c_stop();
        check("t6_wiper", 16'(wiper), 16'h11);

        repeat (20) @(negedge clk);
        check("wr_queue_empty", 16'(q_wr_exp.size()), 16'd0);
        check("bus_queue_empty", 16'(q_bus_exp.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
